// File: rtl/safe_code_controller.sv
// Keypad safe controller: code entry, check, open/relock, reprogramming
// and lockout after repeated failures, sharing one down-counting timer.
module safe_code_controller #(
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234,
  parameter int ENTRY_TIMEOUT = 50_000_000,
  parameter int OPEN_TIME = 250_000_000,
  parameter int LOCKOUT_TIME = 500_000_000,
  parameter int MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       enter_pulse,
  input  logic       clear_pulse,
  input  logic       set_pulse,
  output logic       unlocked,
  output logic       alarm,
  output logic       error,
  output logic [2:0] state,
  output logic [3:0] digit_count,
  output logic [2:0] fail_count
);

  localparam int W = CODE_LEN * 4;
  localparam int TM1 = (ENTRY_TIMEOUT > OPEN_TIME) ? ENTRY_TIMEOUT : OPEN_TIME;
  localparam int TMAX = (TM1 > LOCKOUT_TIME) ? TM1 : LOCKOUT_TIME;
  localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ET_LD = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [TW-1:0] OT_LD = TW'(OPEN_TIME - 1);
  localparam logic [TW-1:0] LT_LD = TW'(LOCKOUT_TIME - 1);
  localparam logic [3:0] LEN4 = 4'(CODE_LEN);
  localparam logic [2:0] MAX3 = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROG    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t st_q, st_n;
  logic [W-1:0] code_q, code_n;
  logic [W-1:0] buf_q, buf_n;
  logic [3:0] cnt_q, cnt_n;
  logic [2:0] fail_q, fail_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic err_q, err_n;

  logic do_clr, do_ent, do_set, do_dig;
  logic full, match;
  logic [W-1:0] shifted;
  logic [2:0] fail_inc;

  // Highest-priority pulse wins; the rest of that cycle is dropped
  assign do_clr = clear_pulse;
  assign do_ent = enter_pulse && !clear_pulse;
  assign do_set = set_pulse && !enter_pulse && !clear_pulse;
  assign do_dig = digit_valid && !set_pulse && !enter_pulse && !clear_pulse;

  assign full = (cnt_q == LEN4);
  assign match = full && (buf_q == code_q);
  assign shifted = {buf_q[W-5:0], digit_in};
  assign fail_inc = fail_q + 3'd1;

  always_comb begin
    st_n = st_q;
    code_n = code_q;
    buf_n = buf_q;
    cnt_n = cnt_q;
    fail_n = fail_q;
    err_n = 1'b0;
    tmr_n = (tmr_q == '0) ? '0 : tmr_q - TW'(1);
    unique case (st_q)
      IDLE: begin
        if (do_dig) begin
          buf_n = {{(W-4){1'b0}}, digit_in};
          cnt_n = 4'd1;
          st_n = ENTRY;
        end
      end
      ENTRY: begin
        if (do_clr) begin
          buf_n = '0;
          cnt_n = '0;
          st_n = IDLE;
        end else if (do_ent) begin
          err_n = !match;
          st_n = CHECK;
        end else if (do_dig && !full) begin
          buf_n = shifted;
          cnt_n = cnt_q + 4'd1;
          tmr_n = ET_LD;
        end else if (tmr_q == '0) begin
          buf_n = '0;
          cnt_n = '0;
          st_n = IDLE;
        end
      end
      CHECK: begin
        buf_n = '0;
        cnt_n = '0;
        if (match) begin
          fail_n = '0;
          st_n = OPEN;
        end else begin
          fail_n = fail_inc;
          st_n = (fail_inc == MAX3) ? LOCKOUT : IDLE;
        end
      end
      OPEN: begin
        if (do_ent) begin
          st_n = IDLE;
        end else if (do_set) begin
          buf_n = '0;
          cnt_n = '0;
          st_n = PROG;
        end else if (tmr_q == '0) begin
          st_n = IDLE;
        end
      end
      PROG: begin
        if (do_clr) begin
          buf_n = '0;
          cnt_n = '0;
        end else if (do_ent) begin
          if (full) code_n = buf_q;
          else err_n = 1'b1;
          buf_n = '0;
          cnt_n = '0;
          st_n = OPEN;
        end else if (do_dig && !full) begin
          buf_n = shifted;
          cnt_n = cnt_q + 4'd1;
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          fail_n = '0;
          st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
    // Every state entry reloads the shared timer
    if (st_n != st_q) begin
      unique case (st_n)
        ENTRY:   tmr_n = ET_LD;
        OPEN:    tmr_n = OT_LD;
        LOCKOUT: tmr_n = LT_LD;
        default: tmr_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      code_q <= DEFAULT_CODE;
      buf_q <= '0;
      cnt_q <= '0;
      fail_q <= '0;
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_n;
      code_q <= code_n;
      buf_q <= buf_n;
      cnt_q <= cnt_n;
      fail_q <= fail_n;
      tmr_q <= tmr_n;
      err_q <= err_n;
    end
  end

  assign unlocked = (st_q == OPEN) || (st_q == PROG);
  assign alarm = (st_q == LOCKOUT);
  assign error = err_q;
  assign state = st_q;
  assign digit_count = cnt_q;
  assign fail_count = fail_q;

endmodule
